// File: rtl/acc_shift_seq.sv
// Request sequencer in front of the accumulator shift register: one shifter step per clock.
// Optional `ACC_SHIFT_CARRY_EN adds a carry output holding the last bit shifted out.
module acc_shift_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [2:0]   req_count,
    input  logic [N-1:0] req_data,
    input  logic [N-1:0] acc_q,
    output logic [1:0]   sh_ctrl,
    output logic [2:0]   sh_num,
    output logic         sh_ls,
    output logic         sh_rs,
    output logic [N-1:0] sh_data,
    output logic         sh_clr_n,
    output logic         busy,
    output logic         done
`ifdef ACC_SHIFT_CARRY_EN
    ,
    output logic         carry
`endif
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t       state_reg, state_next;
    logic [2:0]   op_reg;
    logic [2:0]   cnt_reg;
    logic [N-1:0] data_reg;
    logic         accept;
    logic         req_is_shift;
    logic         op_is_shift;
    logic         op_is_left;
    logic         shift_out;

    assign req_ready    = (state_reg == IDLE) && !clr;
    assign accept       = req_valid && req_ready;
    assign req_is_shift = (req_op != OP_NOP) && (req_op != OP_LOAD) && (req_op != OP_CLR);
    assign op_is_shift  = (op_reg != OP_NOP) && (op_reg != OP_LOAD) && (op_reg != OP_CLR);
    assign op_is_left   = (op_reg == OP_SHL) || (op_reg == OP_ROL);
    assign shift_out    = op_is_left ? acc_q[N-1] : acc_q[0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
            op_reg    <= OP_NOP;
            cnt_reg   <= 3'd0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg   <= req_op;
                cnt_reg  <= req_count;
                data_reg <= req_data;
            end else if (state_reg == EXEC && op_is_shift && cnt_reg != 3'd0) begin
                cnt_reg <= cnt_reg - 3'd1;
            end
        end
    end

    // Each EXEC cycle is one shifter step; rotate/sign-fill bits come from the live acc_q.
    always_comb begin
        state_next = state_reg;
        sh_ctrl    = 2'b00;
        sh_num     = 3'd0;
        sh_ls      = 1'b0;
        sh_rs      = 1'b0;
        sh_data    = '0;
        sh_clr_n   = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_op == OP_LOAD || req_op == OP_CLR ||
                        (req_is_shift && req_count != 3'd0))
                        state_next = EXEC;
                    else
                        state_next = DONE;
                end
            end
            EXEC: begin
                busy = 1'b1;
                unique case (op_reg)
                    OP_LOAD: begin
                        sh_ctrl = 2'b01;
                        sh_data = data_reg;
                    end
                    OP_CLR:  sh_clr_n = 1'b0;
                    OP_SHL:  begin sh_ctrl = 2'b10; sh_num = 3'd1; end
                    OP_ROL:  begin sh_ctrl = 2'b10; sh_num = 3'd1; sh_ls = acc_q[N-1]; end
                    OP_SHR:  begin sh_ctrl = 2'b11; sh_num = 3'd1; end
                    OP_ROR:  begin sh_ctrl = 2'b11; sh_num = 3'd1; sh_rs = acc_q[0]; end
                    OP_ASR:  begin sh_ctrl = 2'b11; sh_num = 3'd1; sh_rs = acc_q[N-1]; end
                    default: ;
                endcase
                // The last step is the one issued while the counter still reads 1.
                if (!op_is_shift || cnt_reg <= 3'd1)
                    state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ACC_SHIFT_CARRY_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            carry <= 1'b0;
        end else if (state_reg == EXEC) begin
            if (op_reg == OP_LOAD || op_reg == OP_CLR)
                carry <= 1'b0;
            else if (op_is_shift)
                carry <= shift_out;
        end
    end
`endif

endmodule

// File: tb/tb_acc_shift_seq.sv
// Bench for acc_shift_seq: a behavioural accumulator shifter closes the loop on acc_q,
// and a scoreboard checks final value and latency at every done pulse.
module tb_acc_shift_seq;
    localparam int N = 8;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    logic         clk = 1'b0;
    logic         clr;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [2:0]   req_count;
    logic [N-1:0] req_data;
    logic [N-1:0] acc_q;
    logic [1:0]   sh_ctrl;
    logic [2:0]   sh_num;
    logic         sh_ls;
    logic         sh_rs;
    logic [N-1:0] sh_data;
    logic         sh_clr_n;
    logic         busy;
    logic         done;
`ifdef ACC_SHIFT_CARRY_EN
    logic         carry;
`endif

    logic [N-1:0] acc = '0;
    assign acc_q = acc;

    always #5 clk = ~clk;

    acc_shift_seq #(.N(N)) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_count(req_count), .req_data(req_data),
        .acc_q(acc_q),
        .sh_ctrl(sh_ctrl), .sh_num(sh_num), .sh_ls(sh_ls), .sh_rs(sh_rs),
        .sh_data(sh_data), .sh_clr_n(sh_clr_n),
        .busy(busy), .done(done)
`ifdef ACC_SHIFT_CARRY_EN
        , .carry(carry)
`endif
    );

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] acc;
        logic         c;
        int           a;
        int           k;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_accept = 0;
    logic carry_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Accumulator shifter as seen by the sequencer; it is not reset by clr.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!sh_clr_n)
            acc <= '0;
        else begin
            case (sh_ctrl)
                2'b01:   acc <= sh_data;
                2'b10:   acc <= {acc[N-2:0], sh_ls};
                2'b11:   acc <= {sh_rs, acc[N-1:1]};
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!clr) begin
            if (sh_ctrl[1]) chk("sh_num", 32'(sh_num), 32'd1);
            if (sh_ctrl != 2'b10) chk("ls_idle", 32'(sh_ls), 32'd0);
            if (sh_ctrl != 2'b11) chk("rs_idle", 32'(sh_rs), 32'd0);
            if (done) begin
                chk("busy_done", 32'(busy), 32'd1);
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("acc", 32'(acc_q), 32'(e.acc));
                    chk("latency", cyc - e.a, e.k);
`ifdef ACC_SHIFT_CARRY_EN
                    chk("carry", 32'(carry), 32'(e.c));
`endif
                    $display("txn op=%0d acc=%02h exp=%02h lat=%0d", e.op, acc_q, e.acc, cyc - e.a);
                end
            end
        end
    end

    function automatic void ref_op(input logic [2:0] op, input logic [2:0] cnt,
                                   input logic [N-1:0] d, input logic [N-1:0] a_in,
                                   input logic c_in, output logic [N-1:0] a,
                                   output logic c, output int k);
        a = a_in;
        c = c_in;
        k = 0;
        case (op)
            OP_NOP:  ;
            OP_LOAD: begin a = d;  c = 1'b0; k = 1; end
            OP_CLR:  begin a = '0; c = 1'b0; k = 1; end
            default: begin
                k = int'(cnt);
                for (int i = 0; i < int'(cnt); i++) begin
                    case (op)
                        OP_SHL:  begin c = a[N-1]; a = a << 1; end
                        OP_ROL:  begin c = a[N-1]; a = {a[N-2:0], a[N-1]}; end
                        OP_SHR:  begin c = a[0];   a = a >> 1; end
                        OP_ASR:  begin c = a[0];   a = {a[N-1], a[N-1:1]}; end
                        default: begin c = a[0];   a = {a[0], a[N-1:1]}; end
                    endcase
                end
            end
        endcase
    endfunction

    // Returns #1 after the accept edge with req_valid dropped.
    task automatic req(input logic [2:0] op, input logic [2:0] cnt, input logic [N-1:0] d);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_count = cnt; req_data = d;
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.op = op;
        ref_op(op, cnt, d, acc, carry_m, e.acc, e.c, e.k);
        carry_m = e.c;
        @(posedge clk);
        #1;
        e.a = cyc;
        last_accept = cyc;
        sb.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int a1;
        clr = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_count = 3'd0; req_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_ctrl", 32'(sh_ctrl), 32'd0);
        chk("rst_clr_n", 32'(sh_clr_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(sh_data), 32'd0);
        clr = 1'b0;
        #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

        // LOAD 0xA5
        req(OP_LOAD, 3'd5, 8'hA5);
        @(negedge clk);
        chk("load_ctrl", 32'(sh_ctrl), 32'd1);
        chk("load_data", 32'(sh_data), 32'hA5);
        chk("exec_ready", 32'(req_ready), 32'd0);
        wait_done();

        // ROL 3 from 0x81: ls sequence 1,0,0
        req(OP_LOAD, 3'd0, 8'h81);
        wait_done();
        req(OP_ROL, 3'd3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rol_ctrl", 32'(sh_ctrl), 32'd2);
            chk("rol_ls", 32'(sh_ls), (i == 0) ? 32'd1 : 32'd0);
        end
        wait_done();

        // ASR 2 from 0x90: rs 1,1
        req(OP_LOAD, 3'd0, 8'h90);
        wait_done();
        req(OP_ASR, 3'd2, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("asr_ctrl", 32'(sh_ctrl), 32'd3);
            chk("asr_rs", 32'(sh_rs), 32'd1);
        end
        wait_done();

        // SHL with zero count: straight to done
        req(OP_SHL, 3'd0, 8'h00);
        @(negedge clk);
        chk("shl0_ctrl", 32'(sh_ctrl), 32'd0);
        chk("shl0_done", 32'(done), 32'd1);
        wait_done();

        // SHR 7 from 0xFF, clr after third shift edge
        req(OP_LOAD, 3'd0, 8'hFF);
        wait_done();
        req(OP_SHR, 3'd7, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        sb.delete();
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ctrl", 32'(sh_ctrl), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        clr = 1'b0;
        carry_m = 1'b0;
        #1;
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_acc", 32'(acc_q), 32'h1F);

        // Back-to-back LOAD then CLR with the requester holding valid
        req(OP_LOAD, 3'd0, 8'h3C);
        a1 = last_accept;
        req(OP_CLR, 3'd4, 8'hFF);
        chk("b2b_gap", last_accept - a1, 3);
        @(negedge clk);
        chk("clr_pulse", 32'(sh_clr_n), 32'd0);
        chk("clr_ctrl", 32'(sh_ctrl), 32'd0);
        @(negedge clk);
        chk("clr_release", 32'(sh_clr_n), 32'd1);
        wait_done();

        // Random mix
        for (int i = 0; i < 24; i++) begin
            req(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom));
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
